// File: rtl/cpu_types_pkg.sv
// Shared CPU types: opcodes and register-index width used across the datapath.
package cpu_types_pkg;

    typedef enum logic [5:0] {
        RTYPE = 6'b000000,
        J     = 6'b000010,
        JAL   = 6'b000011,
        BEQ   = 6'b000100,
        BNE   = 6'b000101,
        ADDI  = 6'b001000,
        LW    = 6'b100011,
        SW    = 6'b101011
    } opcode_t;

    typedef logic [4:0] regbits_t;

endpackage

// File: rtl/data_path_muxs_pkg.sv
// Shared datapath control types, including the hazard unit state encoding.
package data_path_muxs_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        MEM_WAIT   = 2'd1,
        LOAD_STALL = 2'd2,
        HALT       = 2'd3
    } hazard_state_t;

endpackage

// File: rtl/hazard_control_unit_if.sv
// Bundle of hazard control unit signals with views for the block and for a bench.
interface hazard_control_unit_if #(
    parameter int CNT_W = 32
) (
    input logic CLK
);

    logic                         RST;
    logic                         ihit;
    logic                         dhit;
    logic                         dmemREN_EX_MEM;
    logic                         dmemWEN_EX_MEM;
    cpu_types_pkg::opcode_t       opcode_ID_EX;
    cpu_types_pkg::regbits_t      rt_ID_EX;
    cpu_types_pkg::regbits_t      rs_IF_ID;
    cpu_types_pkg::regbits_t      rt_IF_ID;
    logic                         branch_taken_EX_MEM;
    logic                         jump_ID;
    logic                         halt_MEM_WB;
    logic                         pc_en;
    logic                         en_IF_ID;
    logic                         en_ID_EX;
    logic                         en_EX_MEM;
    logic                         en_MEM_WB;
    logic                         flush_IF_ID;
    logic                         flush_ID_EX;
    logic                         flush_EX_MEM;
    logic                         halted;
    data_path_muxs_pkg::hazard_state_t hz_state;
    logic [CNT_W-1:0]             stall_cnt;
    logic [CNT_W-1:0]             flush_cnt;

    modport hcu (
        input  CLK, RST, ihit, dhit, dmemREN_EX_MEM, dmemWEN_EX_MEM, opcode_ID_EX,
               rt_ID_EX, rs_IF_ID, rt_IF_ID, branch_taken_EX_MEM, jump_ID, halt_MEM_WB,
        output pc_en, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB, flush_IF_ID,
               flush_ID_EX, flush_EX_MEM, halted, hz_state, stall_cnt, flush_cnt
    );

    modport tb (
        input  CLK, pc_en, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB, flush_IF_ID,
               flush_ID_EX, flush_EX_MEM, halted, hz_state, stall_cnt, flush_cnt,
        output RST, ihit, dhit, dmemREN_EX_MEM, dmemWEN_EX_MEM, opcode_ID_EX,
               rt_ID_EX, rs_IF_ID, rt_IF_ID, branch_taken_EX_MEM, jump_ID, halt_MEM_WB
    );

endinterface

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating event counter: sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear wins, otherwise step unless already saturated
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: stalls, bubbles and flushes for the 5-stage MIPS core.
module hazard_control_unit
    import cpu_types_pkg::*;
    import data_path_muxs_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          ihit,
    input  logic          dhit,
    input  logic          dmemREN_EX_MEM,
    input  logic          dmemWEN_EX_MEM,
    input  opcode_t       opcode_ID_EX,
    input  regbits_t      rt_ID_EX,
    input  regbits_t      rs_IF_ID,
    input  regbits_t      rt_IF_ID,
    input  logic          branch_taken_EX_MEM,
    input  logic          jump_ID,
    input  logic          halt_MEM_WB,
    output logic          pc_en,
    output logic          en_IF_ID,
    output logic          en_ID_EX,
    output logic          en_EX_MEM,
    output logic          en_MEM_WB,
    output logic          flush_IF_ID,
    output logic          flush_ID_EX,
    output logic          flush_EX_MEM,
    output logic          halted,
    output hazard_state_t hz_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hazard_state_t state_q;
    hazard_state_t state_d;
    logic          dhit_seen_q;
    logic          dhit_seen_d;

    logic mem_op;
    logic dok;
    logic adv;
    logic load_use;
    logic halt_now;
    logic stall_inc;
    logic flush_inc;

    assign mem_op   = dmemREN_EX_MEM | dmemWEN_EX_MEM;
    assign dok      = ~mem_op | dhit | dhit_seen_q;
    assign adv      = ihit & dok & (state_q != HALT);
    assign load_use = (opcode_ID_EX == LW) && (rt_ID_EX != '0) &&
                      ((rt_ID_EX == rs_IF_ID) || (rt_ID_EX == rt_IF_ID));
    assign halt_now = halt_MEM_WB | (state_q == HALT);

    // Remember a data hit that arrived while fetch was still waiting
    always_comb begin
        dhit_seen_d = dhit_seen_q;
        if (adv) begin
            dhit_seen_d = 1'b0;
        end else if (dhit) begin
            dhit_seen_d = 1'b1;
        end
    end

    // State and latched data-hit registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= RUN;
            dhit_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dhit_seen_q <= dhit_seen_d;
        end
    end

    // Next state, following the same priority as the outputs
    always_comb begin
        state_d = state_q;
        if (halt_now) begin
            state_d = HALT;
        end else if (!adv) begin
            if (mem_op && !dok) begin
                state_d = MEM_WAIT;
            end
        end else if (branch_taken_EX_MEM) begin
            state_d = RUN;
        end else if ((state_q != LOAD_STALL) && load_use) begin
            state_d = LOAD_STALL;
        end else begin
            state_d = RUN;
        end
    end

    // Latch controls and counter strobes; reset holds everything quiet
    always_comb begin
        pc_en        = 1'b0;
        en_IF_ID     = 1'b0;
        en_ID_EX     = 1'b0;
        en_EX_MEM    = 1'b0;
        en_MEM_WB    = 1'b0;
        flush_IF_ID  = 1'b0;
        flush_ID_EX  = 1'b0;
        flush_EX_MEM = 1'b0;
        halted       = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        if (!RST) begin
            if (halt_now) begin
                halted = 1'b1;
            end else if (!adv) begin
                stall_inc = 1'b1;
            end else if (branch_taken_EX_MEM) begin
                pc_en        = 1'b1;
                en_IF_ID     = 1'b1;
                en_ID_EX     = 1'b1;
                en_EX_MEM    = 1'b1;
                en_MEM_WB    = 1'b1;
                flush_IF_ID  = 1'b1;
                flush_ID_EX  = 1'b1;
                flush_EX_MEM = 1'b1;
                flush_inc    = 1'b1;
            end else if ((state_q != LOAD_STALL) && load_use) begin
                en_ID_EX    = 1'b1;
                flush_ID_EX = 1'b1;
                en_EX_MEM   = 1'b1;
                en_MEM_WB   = 1'b1;
                stall_inc   = 1'b1;
            end else begin
                pc_en       = 1'b1;
                en_IF_ID    = 1'b1;
                en_ID_EX    = 1'b1;
                en_EX_MEM   = 1'b1;
                en_MEM_WB   = 1'b1;
                flush_IF_ID = jump_ID;
                flush_inc   = jump_ID;
            end
        end
    end

    assign hz_state = state_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (CLK),
        .inc   (stall_inc),
        .clear (RST),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (CLK),
        .inc   (flush_inc),
        .clear (RST),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboarded bench for the hazard control unit (narrow counters to reach saturation).
module tb_hazard_control_unit;
    import cpu_types_pkg::*;
    import data_path_muxs_pkg::*;

    localparam int CW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    hazard_control_unit_if #(.CNT_W(CW)) hif (.CLK(clk));

    hazard_control_unit #(.CNT_W(CW)) dut (
        .CLK                 (hif.CLK),
        .RST                 (hif.RST),
        .ihit                (hif.ihit),
        .dhit                (hif.dhit),
        .dmemREN_EX_MEM      (hif.dmemREN_EX_MEM),
        .dmemWEN_EX_MEM      (hif.dmemWEN_EX_MEM),
        .opcode_ID_EX        (hif.opcode_ID_EX),
        .rt_ID_EX            (hif.rt_ID_EX),
        .rs_IF_ID            (hif.rs_IF_ID),
        .rt_IF_ID            (hif.rt_IF_ID),
        .branch_taken_EX_MEM (hif.branch_taken_EX_MEM),
        .jump_ID             (hif.jump_ID),
        .halt_MEM_WB         (hif.halt_MEM_WB),
        .pc_en               (hif.pc_en),
        .en_IF_ID            (hif.en_IF_ID),
        .en_ID_EX            (hif.en_ID_EX),
        .en_EX_MEM           (hif.en_EX_MEM),
        .en_MEM_WB           (hif.en_MEM_WB),
        .flush_IF_ID         (hif.flush_IF_ID),
        .flush_ID_EX         (hif.flush_ID_EX),
        .flush_EX_MEM        (hif.flush_EX_MEM),
        .halted              (hif.halted),
        .hz_state            (hif.hz_state),
        .stall_cnt           (hif.stall_cnt),
        .flush_cnt           (hif.flush_cnt)
    );

    int checks = 0;
    int errors = 0;
    logic [10:0] sb[$];
    logic [10:0] monExp;
    logic [10:0] monGot;

    // Pack {pc_en, en IF/ID/EX/MEM..WB, flush IF/ID/EX, halted, state}
    function automatic logic [10:0] mk(input logic pc, input logic [3:0] en,
                                       input logic [2:0] fl, input logic h,
                                       input hazard_state_t st);
        return {pc, en, fl, h, st};
    endfunction

    // Compare each cycle's outputs mid-cycle against the queued expectation
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            monExp = sb.pop_front();
            monGot = {hif.pc_en, hif.en_IF_ID, hif.en_ID_EX, hif.en_EX_MEM, hif.en_MEM_WB,
                      hif.flush_IF_ID, hif.flush_ID_EX, hif.flush_EX_MEM, hif.halted,
                      hif.hz_state};
            checks++;
            if (monGot !== monExp) begin
                errors++;
                $display("[TB] FAIL cycle_outputs t=%0t pc/en/fl/halt/st got=%b required=%b",
                         $time, monGot, monExp);
            end
        end
    end

    task automatic setIdle();
        hif.RST                 = 1'b0;
        hif.ihit                = 1'b1;
        hif.dhit                = 1'b0;
        hif.dmemREN_EX_MEM      = 1'b0;
        hif.dmemWEN_EX_MEM      = 1'b0;
        hif.opcode_ID_EX        = RTYPE;
        hif.rt_ID_EX            = 5'd0;
        hif.rs_IF_ID            = 5'd0;
        hif.rt_IF_ID            = 5'd0;
        hif.branch_taken_EX_MEM = 1'b0;
        hif.jump_ID             = 1'b0;
        hif.halt_MEM_WB         = 1'b0;
    endtask

    // Queue the expectation for the current cycle, then advance one edge
    task automatic step(input logic [10:0] e);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        setIdle();
        hif.RST = 1'b1;
        step(mk(0, 4'b0000, 3'b000, 0, RUN));
        step(mk(0, 4'b0000, 3'b000, 0, RUN));
        checks++;
        if (hif.stall_cnt !== 4'd0 || hif.flush_cnt !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset_counters got stall=%0d flush=%0d required 0/0",
                     hif.stall_cnt, hif.flush_cnt);
        end
        hif.RST = 1'b0;
        step(mk(1, 4'b1111, 3'b000, 0, RUN));
    endtask

    task automatic test_load_use();
        hif.opcode_ID_EX = LW;
        hif.rt_ID_EX     = 5'd5;
        hif.rs_IF_ID     = 5'd5;
        hif.rt_IF_ID     = 5'd7;
        step(mk(0, 4'b0111, 3'b010, 0, RUN));
        step(mk(1, 4'b1111, 3'b000, 0, LOAD_STALL));
        checks++;
        if (hif.stall_cnt !== 4'd1) begin
            errors++;
            $display("[TB] FAIL load_use_stall_cnt got=%0d required=1", hif.stall_cnt);
        end
        hif.rt_ID_EX = 5'd0;
        hif.rs_IF_ID = 5'd0;
        hif.rt_IF_ID = 5'd0;
        step(mk(1, 4'b1111, 3'b000, 0, RUN));
        checks++;
        if (hif.stall_cnt !== 4'd1) begin
            errors++;
            $display("[TB] FAIL load_use_r0_stall_cnt got=%0d required=1", hif.stall_cnt);
        end
        hif.rt_ID_EX = 5'd9;
        hif.rs_IF_ID = 5'd3;
        hif.rt_IF_ID = 5'd9;
        step(mk(0, 4'b0111, 3'b010, 0, RUN));
        step(mk(1, 4'b1111, 3'b000, 0, LOAD_STALL));
        checks++;
        if (hif.stall_cnt !== 4'd2) begin
            errors++;
            $display("[TB] FAIL load_use_rt_stall_cnt got=%0d required=2", hif.stall_cnt);
        end
        setIdle();
    endtask

    task automatic test_data_wait();
        hif.dmemREN_EX_MEM = 1'b1;
        hif.ihit = 1'b0;
        hif.dhit = 1'b0;
        step(mk(0, 4'b0000, 3'b000, 0, RUN));
        hif.dhit = 1'b1;
        step(mk(0, 4'b0000, 3'b000, 0, MEM_WAIT));
        hif.dhit = 1'b0;
        step(mk(0, 4'b0000, 3'b000, 0, MEM_WAIT));
        hif.ihit = 1'b1;
        step(mk(1, 4'b1111, 3'b000, 0, MEM_WAIT));
        hif.dmemREN_EX_MEM = 1'b0;
        hif.dmemWEN_EX_MEM = 1'b1;
        step(mk(0, 4'b0000, 3'b000, 0, RUN));
        hif.dhit = 1'b1;
        step(mk(1, 4'b1111, 3'b000, 0, MEM_WAIT));
        checks++;
        if (hif.stall_cnt !== 4'd6) begin
            errors++;
            $display("[TB] FAIL data_wait_stall_cnt got=%0d required=6", hif.stall_cnt);
        end
        setIdle();
        step(mk(1, 4'b1111, 3'b000, 0, RUN));
    endtask

    task automatic test_branch_vs_load_use();
        hif.opcode_ID_EX        = LW;
        hif.rt_ID_EX            = 5'd5;
        hif.rs_IF_ID            = 5'd5;
        hif.branch_taken_EX_MEM = 1'b1;
        step(mk(1, 4'b1111, 3'b111, 0, RUN));
        checks++;
        if (hif.flush_cnt !== 4'd1) begin
            errors++;
            $display("[TB] FAIL branch_flush_cnt got=%0d required=1", hif.flush_cnt);
        end
        hif.branch_taken_EX_MEM = 1'b0;
        step(mk(0, 4'b0111, 3'b010, 0, RUN));
        step(mk(1, 4'b1111, 3'b000, 0, LOAD_STALL));
        hif.opcode_ID_EX        = RTYPE;
        hif.branch_taken_EX_MEM = 1'b1;
        hif.jump_ID             = 1'b1;
        step(mk(1, 4'b1111, 3'b111, 0, RUN));
        checks++;
        if (hif.flush_cnt !== 4'd2 || hif.stall_cnt !== 4'd7) begin
            errors++;
            $display("[TB] FAIL branch_jump_counts got flush=%0d stall=%0d required 2/7",
                     hif.flush_cnt, hif.stall_cnt);
        end
        setIdle();
    endtask

    task automatic test_jump();
        hif.jump_ID = 1'b1;
        step(mk(1, 4'b1111, 3'b100, 0, RUN));
        checks++;
        if (hif.flush_cnt !== 4'd3) begin
            errors++;
            $display("[TB] FAIL jump_flush_cnt got=%0d required=3", hif.flush_cnt);
        end
        hif.opcode_ID_EX = LW;
        hif.rt_ID_EX     = 5'd5;
        hif.rs_IF_ID     = 5'd5;
        step(mk(0, 4'b0111, 3'b010, 0, RUN));
        step(mk(1, 4'b1111, 3'b100, 0, LOAD_STALL));
        checks++;
        if (hif.flush_cnt !== 4'd4 || hif.stall_cnt !== 4'd8) begin
            errors++;
            $display("[TB] FAIL jump_after_stall_counts got flush=%0d stall=%0d required 4/8",
                     hif.flush_cnt, hif.stall_cnt);
        end
        setIdle();
        step(mk(1, 4'b1111, 3'b000, 0, RUN));
    endtask

    task automatic test_halt();
        hif.halt_MEM_WB = 1'b1;
        step(mk(0, 4'b0000, 3'b000, 1, RUN));
        hif.halt_MEM_WB         = 1'b0;
        hif.branch_taken_EX_MEM = 1'b1;
        hif.jump_ID             = 1'b1;
        step(mk(0, 4'b0000, 3'b000, 1, HALT));
        hif.branch_taken_EX_MEM = 1'b0;
        hif.jump_ID             = 1'b0;
        step(mk(0, 4'b0000, 3'b000, 1, HALT));
        step(mk(0, 4'b0000, 3'b000, 1, HALT));
        checks++;
        if (hif.stall_cnt !== 4'd8 || hif.flush_cnt !== 4'd4) begin
            errors++;
            $display("[TB] FAIL halt_counters_frozen got stall=%0d flush=%0d required 8/4",
                     hif.stall_cnt, hif.flush_cnt);
        end
        hif.RST = 1'b1;
        step(mk(0, 4'b0000, 3'b000, 0, HALT));
        hif.RST = 1'b0;
        step(mk(1, 4'b1111, 3'b000, 0, RUN));
        checks++;
        if (hif.stall_cnt !== 4'd0 || hif.flush_cnt !== 4'd0) begin
            errors++;
            $display("[TB] FAIL halt_reset_counters got stall=%0d flush=%0d required 0/0",
                     hif.stall_cnt, hif.flush_cnt);
        end
    endtask

    task automatic test_saturation();
        hif.jump_ID = 1'b1;
        repeat (17) step(mk(1, 4'b1111, 3'b100, 0, RUN));
        checks++;
        if (hif.flush_cnt !== 4'd15) begin
            errors++;
            $display("[TB] FAIL flush_cnt_saturate got=%0d required=15", hif.flush_cnt);
        end
        hif.jump_ID = 1'b0;
        hif.ihit    = 1'b0;
        repeat (17) step(mk(0, 4'b0000, 3'b000, 0, RUN));
        checks++;
        if (hif.stall_cnt !== 4'd15) begin
            errors++;
            $display("[TB] FAIL stall_cnt_saturate got=%0d required=15", hif.stall_cnt);
        end
        setIdle();
        step(mk(1, 4'b1111, 3'b000, 0, RUN));
        checks++;
        if (hif.stall_cnt !== 4'd15 || hif.flush_cnt !== 4'd15) begin
            errors++;
            $display("[TB] FAIL counters_hold_saturated got stall=%0d flush=%0d required 15/15",
                     hif.stall_cnt, hif.flush_cnt);
        end
    endtask

    initial begin
        setIdle();
        hif.RST = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_data_wait();
        test_branch_vs_load_use();
        test_jump();
        test_halt();
        test_saturation();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain got=%0d pending required=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline-control block for the 5-stage MIPS datapath. Works alongside the forwarding logic:
- It detects the hazards forwarding cannot cover: load-use, branch/jump redirect, instruction/data cache wait, and halt.
- It drives the enable, flush and PC-enable signals of the IF/ID, ID/EX, EX/MEM and MEM/WB latches.
- It tracks a latched data-hit flag, a one-cycle load-use stall state and a sticky halt, and keeps stall/flush performance counters.

## Interface
Parameters:
- CNT_W, default 32: width of the performance counters.

Ports:
- CLK  in  1  system clock
- RST  in  1  reset; synchronous, active-high
- ihit  in  1  instruction cache returned an instruction this cycle
- dhit  in  1  data cache completed the MEM-stage access this cycle
- dmemREN_EX_MEM  in  1  MEM-stage load
- dmemWEN_EX_MEM  in  1  MEM-stage store
- opcode_ID_EX  in  6 (opcode_t)  opcode in EX
- rt_ID_EX  in  5 (regbits_t)  destination rt of the EX instruction
- rs_IF_ID  in  5 (regbits_t)  source rs of the ID instruction
- rt_IF_ID  in  5 (regbits_t)  source rt of the ID instruction
- branch_taken_EX_MEM  in  1  branch resolved taken in MEM
- jump_ID  in  1  J/JAL/JR decoded in ID
- halt_MEM_WB  in  1  HALT reached WB
- pc_en  out  1  PC register load
- en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB  out  1 each  latch enables
- flush_IF_ID, flush_ID_EX, flush_EX_MEM  out  1 each  load NOP into latch; effective only when that latch's enable is 1
- halted  out  1  sticky halt indication
- hz_state  out  2 (hazard_state_t)  current FSM state
- stall_cnt  out  CNT_W  cycles with pc_en=0 while not halted; saturating
- flush_cnt  out  CNT_W  redirect events; saturating

## Operation
Internal terms:
- mem_op = dmemREN_EX_MEM | dmemWEN_EX_MEM
- dok = ~mem_op | dhit | dhit_seen
- adv = ihit & dok & state≠HALT
- load_use = (opcode_ID_EX==LW) & (rt_ID_EX≠0) & (rt_ID_EX==rs_IF_ID | rt_ID_EX==rt_IF_ID)

dhit_seen register:
- Set when dhit & ~adv.
- Cleared on adv.
- Prevents losing a one-cycle dhit while ihit is low.

States:
- RUN
- MEM_WAIT: mem_op & ~dok
- LOAD_STALL
- HALT

Per-cycle outputs, in priority order:
1. halt_MEM_WB or state HALT:
   - all enables, pc_en and flushes = 0; halted = 1.
   - Next state HALT. Only RST exits.
2. ~adv:
   - all enables and pc_en = 0.
   - Next state MEM_WAIT if mem_op & ~dok, else unchanged (RUN or LOAD_STALL).
3. adv & branch_taken_EX_MEM:
   - all enables = 1, pc_en = 1.
   - flush_IF_ID = flush_ID_EX = flush_EX_MEM = 1.
   - flush_cnt increments. Next state RUN.
4. adv & state≠LOAD_STALL & load_use:
   - pc_en = 0, en_IF_ID = 0.
   - en_ID_EX = 1 with flush_ID_EX = 1 (inserts a bubble).
   - en_EX_MEM = en_MEM_WB = 1.
   - Next state LOAD_STALL.
5. adv & jump_ID:
   - all enables = 1, pc_en = 1, flush_IF_ID = 1.
   - flush_cnt increments. Next state RUN.
6. adv, otherwise:
   - all enables = 1, pc_en = 1, flushes = 0.
   - Next state RUN.
   - In LOAD_STALL, load_use is ignored (rule 4 skipped), so the stall lasts exactly one advancing cycle.

Boundary conditions:
- Branch and load_use in the same cycle: branch wins; the load is flushed.
- Branch and jump in the same cycle: branch wins.
- load_use with rt_ID_EX = $0 never stalls.
- Counters saturate at all-ones.

## Timing
- Reset value of every output: enables 0, flushes 0, pc_en 0, halted 0, hz_state RUN, stall_cnt 0, flush_cnt 0.
- Reset also clears dhit_seen.
- RST asserted mid-stall or in HALT returns everything to reset values at the next edge.
- All outputs are combinational from registered state/dhit_seen and current inputs.
- Registers update on the CLK rising edge.
- Latency of a redirect or bubble: zero cycles; it takes effect at the same edge.
- Counters and hz_state update one edge after the qualifying cycle.

## Structure
Shared package data_path_muxs_pkg holds:
- hazard_state_t (RUN=0, MEM_WAIT=1, LOAD_STALL=2, HALT=3)

cpu_types_pkg provides:
- opcode_t, regbits_t, LW

Block organisation:
- An interface hazard_control_unit_if carries the ports, with a modport for the block (hcu) and a modport for the bench (tb).
- One sub-module is natural: sat_counter (parameter W; ports inc and clear), instantiated twice.

## Test plan
- Reset: assert RST for 2 cycles with ihit=1. Required: all outputs at reset values; after release with no hazard, all enables = 1 and pc_en = 1.
- Load-use: opcode_ID_EX=LW, rt_ID_EX=5, rs_IF_ID=5, ihit=1, no mem_op. Required: one cycle with pc_en=0, en_IF_ID=0, flush_ID_EX=1; next cycle all enables = 1; stall_cnt=1. Repeat with rt_ID_EX=0: no stall.
- Data wait with late ihit: mem_op=1, dhit pulses in cycle 2 while ihit=0, ihit=1 in cycle 4. Required: hz_state MEM_WAIT; all enables 0 through cycle 3; adv in cycle 4; dhit_seen cleared afterwards.
- Branch vs load-use: branch_taken_EX_MEM=1 with load_use true and ihit=1. Required: all three flushes = 1, pc_en=1, flush_cnt=1, no LOAD_STALL entry.
- Jump: jump_ID=1, ihit=1. Required: flush_IF_ID=1 only; pc_en=1.
- Halt: halt_MEM_WB=1 for one cycle. Required: halted=1 and all enables 0 indefinitely, stall_cnt frozen; RST returns hz_state to RUN.
